// File: rtl/accumulator_unit_pkg.sv
// -----------------------------------------------------------------------------
// accumulator_unit_pkg
//
// Shared definitions for the SAP-1 accumulator/B-register unit:
//   - WIDTH_DEFAULT : default datapath width of A, B, the result and the W-bus
//   - state_t       : controller FSM encoding (IDLE, EXEC, WB)
//   - op_t          : arithmetic operation select (OP_ADD, OP_SUB)
// -----------------------------------------------------------------------------
package accumulator_unit_pkg;

    localparam int WIDTH_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WB   = 2'd2
    } state_t;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_t;

endpackage : accumulator_unit_pkg

// File: rtl/accumulator_unit_addsub.sv
// -----------------------------------------------------------------------------
// adder_subtracter
//
// Purely combinational two's-complement adder-subtracter.
//   a, b  : operands (WIDTH bits)
//   sub   : 0 -> s = a + b, 1 -> s = a + ~b + 1 (i.e. a - b)
//   s     : result, modulo 2^WIDTH
//   carry : carry out of the MSB; for subtract, 1 means no borrow (a >= b)
// -----------------------------------------------------------------------------
module adder_subtracter #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic [WIDTH-1:0] s,
    output logic             carry
);

    logic [WIDTH-1:0] b_op;
    logic [WIDTH:0]   full_sum;

    // Subtract is done as a + ~b + 1: invert b and feed sub in as the carry-in.
    assign b_op     = sub ? ~b : b;
    assign full_sum = {1'b0, a} + {1'b0, b_op} + {{WIDTH{1'b0}}, sub};
    assign s        = full_sum[WIDTH-1:0];
    assign carry    = full_sum[WIDTH];

endmodule : adder_subtracter

// File: rtl/accumulator_unit.sv
// -----------------------------------------------------------------------------
// accumulator_unit
//
// Operand-supply and result-capture side of the SAP-1 adder-subtracter.
// Holds the A (accumulator) and B registers, runs one handshaked add/subtract
// per start request, writes the result back into A and keeps status flags.
//
// Ports:
//   clk, rst     : clock and synchronous active-high reset
//   bus_in       : W-bus value for register loads
//   la, lb       : load A / load B from bus_in (honoured in IDLE only)
//   start, su    : request an operation; su selects add (0) or subtract (1)
//   ea           : drive A onto the bus (combinational, legal in any state)
//   bus_out      : A when ea=1, else 0
//   bus_oe       : bus-driver enable, equals ea
//   a_q, b_q     : current A and B register contents
//   busy         : high while in EXEC or WB
//   done         : one-cycle pulse in the cycle after A is written back
//   carry_flag   : carry out of the last operation (subtract: 1 = no borrow)
//   zero_flag    : last result was zero
//   neg_flag     : MSB of the last result
//   ovf_flag     : signed overflow of the last operation
//
// Handshake: start is a single-cycle request sampled only in IDLE (busy=0).
// Sampled at edge k, the operation reads A/B at edge k+1, writes A and the
// flags at edge k+2, and done is high for exactly the cycle after edge k+2.
// While busy=1, start, la and lb are ignored. A new start can be taken at
// edge k+3, the same cycle done is high.
// -----------------------------------------------------------------------------
module accumulator_unit
    import accumulator_unit_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] bus_in,
    input  logic             la,
    input  logic             lb,
    input  logic             start,
    input  logic             su,
    input  logic             ea,
    output logic [WIDTH-1:0] bus_out,
    output logic             bus_oe,
    output logic [WIDTH-1:0] a_q,
    output logic [WIDTH-1:0] b_q,
    output logic             busy,
    output logic             done,
    output logic             carry_flag,
    output logic             zero_flag,
    output logic             neg_flag,
    output logic             ovf_flag
);

    localparam int MSB = WIDTH - 1;

    state_t           state;
    op_t              op_r;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] result_r;
    logic             carry_r;
    logic             ovf_r;
    logic             done_r;
    logic             carry_r_flag;
    logic             zero_r_flag;
    logic             neg_r_flag;
    logic             ovf_r_flag;

    logic [WIDTH-1:0] sum;
    logic             sum_carry;
    logic             b_op_msb;
    logic             ovf_now;

    adder_subtracter #(
        .WIDTH (WIDTH)
    ) u_addsub (
        .a     (a_r),
        .b     (b_r),
        .sub   (op_r == OP_SUB),
        .s     (sum),
        .carry (sum_carry)
    );

    // Signed overflow: operands (B inverted for subtract) agree in sign and
    // the result sign differs from them.
    assign b_op_msb = (op_r == OP_SUB) ? ~b_r[MSB] : b_r[MSB];
    assign ovf_now  = (a_r[MSB] == b_op_msb) && (sum[MSB] != a_r[MSB]);

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            op_r         <= OP_ADD;
            a_r          <= '0;
            b_r          <= '0;
            result_r     <= '0;
            carry_r      <= 1'b0;
            ovf_r        <= 1'b0;
            done_r       <= 1'b0;
            carry_r_flag <= 1'b0;
            zero_r_flag  <= 1'b0;
            neg_r_flag   <= 1'b0;
            ovf_r_flag   <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (la) a_r <= bus_in;
                    if (lb) b_r <= bus_in;
                    if (start) begin
                        op_r  <= su ? OP_SUB : OP_ADD;
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    // Operands are read here, so loads made together with
                    // start are already visible to the operation.
                    result_r <= sum;
                    carry_r  <= sum_carry;
                    ovf_r    <= ovf_now;
                    state    <= WB;
                end
                WB: begin
                    a_r          <= result_r;
                    carry_r_flag <= carry_r;
                    zero_r_flag  <= (result_r == '0);
                    neg_r_flag   <= result_r[MSB];
                    ovf_r_flag   <= ovf_r;
                    done_r       <= 1'b1;
                    state        <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign busy       = (state == EXEC) || (state == WB);
    assign done       = done_r;
    assign a_q        = a_r;
    assign b_q        = b_r;
    assign carry_flag = carry_r_flag;
    assign zero_flag  = zero_r_flag;
    assign neg_flag   = neg_r_flag;
    assign ovf_flag   = ovf_r_flag;

    // Bus drive has no register stage: A appears on the bus in the same cycle
    // ea is raised, including mid-operation (pre-writeback value).
    assign bus_oe  = ea;
    assign bus_out = ea ? a_r : '0;

endmodule : accumulator_unit

// File: tb/tb_accumulator_unit.sv
// -----------------------------------------------------------------------------
// tb_accumulator_unit
//
// Self-checking bench for accumulator_unit. A behavioural model computes each
// result from signed/unsigned integer arithmetic and compares A, B, the flags,
// busy, done and the bus outputs at fixed points of every operation.
// -----------------------------------------------------------------------------
module tb_accumulator_unit;

    logic       clk;
    logic       rst;
    logic [7:0] bus_in;
    logic       la;
    logic       lb;
    logic       start;
    logic       su;
    logic       ea;
    logic [7:0] bus_out;
    logic       bus_oe;
    logic [7:0] a_q;
    logic [7:0] b_q;
    logic       busy;
    logic       done;
    logic       carry_flag;
    logic       zero_flag;
    logic       neg_flag;
    logic       ovf_flag;

    int checks   = 0;
    int failures = 0;

    // Model state
    int m_a, m_b, m_c, m_z, m_n, m_v;

    accumulator_unit #(.WIDTH(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus_in     (bus_in),
        .la         (la),
        .lb         (lb),
        .start      (start),
        .su         (su),
        .ea         (ea),
        .bus_out    (bus_out),
        .bus_oe     (bus_oe),
        .a_q        (a_q),
        .b_q        (b_q),
        .busy       (busy),
        .done       (done),
        .carry_flag (carry_flag),
        .zero_flag  (zero_flag),
        .neg_flag   (neg_flag),
        .ovf_flag   (ovf_flag)
    );

    // Clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance past the next rising edge; outputs are sampled 1 ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model of one operation using plain integer arithmetic.
    task automatic model_op(input int su_v);
        int sa, sb, sres, ures;
        sa = (m_a >= 128) ? m_a - 256 : m_a;
        sb = (m_b >= 128) ? m_b - 256 : m_b;
        if (su_v != 0) begin
            sres = sa - sb;
            ures = m_a - m_b;
            m_c  = (m_a >= m_b) ? 1 : 0;
        end else begin
            sres = sa + sb;
            ures = m_a + m_b;
            m_c  = (ures > 255) ? 1 : 0;
        end
        m_v = (sres > 127 || sres < -128) ? 1 : 0;
        m_a = ures & 255;
        m_z = (m_a == 0) ? 1 : 0;
        m_n = (m_a >= 128) ? 1 : 0;
    endtask

    task automatic check_regs(input string tag);
        chk({tag, ".a_q"},   32'(a_q),        32'(m_a));
        chk({tag, ".b_q"},   32'(b_q),        32'(m_b));
        chk({tag, ".carry"}, 32'(carry_flag), 32'(m_c));
        chk({tag, ".zero"},  32'(zero_flag),  32'(m_z));
        chk({tag, ".neg"},   32'(neg_flag),   32'(m_n));
        chk({tag, ".ovf"},   32'(ovf_flag),   32'(m_v));
        chk({tag, ".bus"},   32'(bus_out),    ea ? 32'(m_a) : 32'd0);
    endtask

    // Driver: load operands, run one operation, check every cycle of it.
    //   simul : load B first, then raise la together with start
    //   poke  : assert la/lb/start with bus_in=0xAA while busy (must be ignored)
    task automatic run_op(input string tag, input int a_v, input int b_v,
                          input int su_v, input bit simul, input bit poke);
        if (!simul) begin
            bus_in = 8'(a_v); la = 1'b1;
            tick();
            la = 1'b0; m_a = a_v;
            bus_in = 8'(b_v); lb = 1'b1;
            tick();
            lb = 1'b0; m_b = b_v;
            check_regs({tag, ".load"});      // loads leave flags untouched
            start = 1'b1; su = su_v[0];
            tick();                          // edge k
        end else begin
            bus_in = 8'(b_v); lb = 1'b1;
            tick();
            lb = 1'b0; m_b = b_v;
            bus_in = 8'(a_v); la = 1'b1; start = 1'b1; su = su_v[0];
            tick();                          // edge k
            la = 1'b0; m_a = a_v;
        end
        start = 1'b0;
        chk({tag, ".busy_k"}, 32'(busy), 32'd1);
        chk({tag, ".done_k"}, 32'(done), 32'd0);
        chk({tag, ".bus_k"},  32'(bus_out), ea ? 32'(m_a) : 32'd0);
        if (poke) begin
            bus_in = 8'hAA; la = 1'b1; lb = 1'b1; start = 1'b1;
        end
        tick();                              // edge k+1
        la = 1'b0; lb = 1'b0; start = 1'b0;
        chk({tag, ".busy_k1"}, 32'(busy), 32'd1);
        chk({tag, ".done_k1"}, 32'(done), 32'd0);
        chk({tag, ".a_k1"},    32'(a_q),  32'(m_a));
        tick();                              // edge k+2
        model_op(su_v);
        chk({tag, ".busy_k2"}, 32'(busy), 32'd0);
        chk({tag, ".done_k2"}, 32'(done), 32'd1);
        check_regs({tag, ".wb"});
        tick();                              // edge k+3
        chk({tag, ".done_k3"}, 32'(done), 32'd0);
        chk({tag, ".busy_k3"}, 32'(busy), 32'd0);
    endtask

    initial begin
        rst = 1'b1; ea = 1'b1; la = 1'b0; lb = 1'b0;
        start = 1'b0; su = 1'b0; bus_in = 8'h00;
        m_a = 0; m_b = 0; m_c = 0; m_z = 0; m_n = 0; m_v = 0;

        // 1. Reset
        tick();
        tick();
        rst = 1'b0;
        check_regs("reset");
        chk("reset.busy",   32'(busy),   32'd0);
        chk("reset.done",   32'(done),   32'd0);
        chk("reset.bus_oe", 32'(bus_oe), 32'd1);

        // 2-5. Directed arithmetic cases
        run_op("add_5_3",   8'h05, 8'h03, 0, 1'b0, 1'b0);
        run_op("add_ff_1",  8'hFF, 8'h01, 0, 1'b0, 1'b0);
        run_op("sub_3_5",   8'h03, 8'h05, 1, 1'b0, 1'b0);
        run_op("sub_5_3",   8'h05, 8'h03, 1, 1'b0, 1'b0);
        run_op("add_7f_1",  8'h7F, 8'h01, 0, 1'b0, 1'b0);
        run_op("sub_80_1",  8'h80, 8'h01, 1, 1'b0, 1'b1);
        run_op("sub_eq",    8'h5A, 8'h5A, 1, 1'b0, 1'b0);

        // Bus enable off: bus shows 0 and enable is low
        ea = 1'b0;
        #1;
        chk("ea_off.bus",    32'(bus_out), 32'd0);
        chk("ea_off.bus_oe", 32'(bus_oe),  32'd0);
        run_op("add_ea_off", 8'h12, 8'h34, 0, 1'b0, 1'b0);
        ea = 1'b1;
        #1;
        chk("ea_on.bus", 32'(bus_out), 32'(m_a));

        // Randomized operations
        for (int i = 0; i < 24; i++) begin
            run_op($sformatf("rand%0d", i), int'($urandom_range(0, 255)),
                   int'($urandom_range(0, 255)), int'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        // 6. Reset mid-operation aborts it
        bus_in = 8'h40; la = 1'b1;
        tick();
        la = 1'b0;
        bus_in = 8'h01; lb = 1'b1;
        tick();
        lb = 1'b0;
        start = 1'b1; su = 1'b0;
        tick();                              // edge k
        start = 1'b0;
        rst = 1'b1;
        tick();                              // edge k+1 under reset
        rst = 1'b0;
        m_a = 0; m_b = 0; m_c = 0; m_z = 0; m_n = 0; m_v = 0;
        check_regs("abort");
        chk("abort.busy", 32'(busy), 32'd0);
        chk("abort.done", 32'(done), 32'd0);
        tick();
        chk("abort.done_next", 32'(done), 32'd0);
        chk("abort.a_next",    32'(a_q),  32'd0);
        tick();
        chk("abort.done_late", 32'(done), 32'd0);

        // Simultaneous load A with start: operation uses the new A
        run_op("simul", 8'h10, 8'h01, 0, 1'b1, 1'b0);
        chk("simul.a_11", 32'(a_q), 32'h11);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_accumulator_unit

// File: doc/accumulator_unit.md
Name: accumulator_unit

Overview:
SAP-1 accumulator/B-register unit: the operand-supply and result-capture side of the 8-bit adder-subtracter. Loads A and B from the W-bus and runs a handshaked add/subtract through the combinational adder-subtracter. Writes the result back into A, updates status flags, and drives A onto the W-bus on request. Sits between the controller-sequencer (control lines, start/done) and the W-bus.

Parameters:
WIDTH, 8, datapath width of A, B, the result and the bus (the test plan exercises 8 only).

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous, active-high reset
bus_in  input  WIDTH  W-bus value for register loads
la  input  1  load A from bus_in
lb  input  1  load B from bus_in
start  input  1  request one arithmetic operation
su  input  1  operation select sampled with start: 0 = A+B, 1 = A-B
ea  input  1  drive A onto the bus
bus_out  output  WIDTH  A when ea=1, else 0
bus_oe  output  1  equals ea; bus-driver enable
a_q  output  WIDTH  current A register
b_q  output  WIDTH  current B register
busy  output  1  high in EXEC and WB states
done  output  1  one-cycle pulse after A is written back
carry_flag  output  1  carry out of last operation; for subtract, 1 = no borrow
zero_flag  output  1  last result == 0
neg_flag  output  1  last result MSB
ovf_flag  output  1  signed two's-complement overflow of last operation

Behaviour:
- Reset (rst=1 at an edge): A, B, result_r, op_r, all flags = 0; state = IDLE; done = 0; busy = 0. bus_out follows ea combinationally, so it shows 0 after reset.
- Reset wins over every other input.
- Reset mid-operation aborts the operation: no done pulse, no writeback.
- FSM states: IDLE, EXEC, WB.
  - IDLE: la/lb load A/B at the edge. start=1 latches su into op_r and moves to EXEC.
  - EXEC: result_r and carry_r are captured from the adder-subtracter using the current A, B and op_r; next state WB.
  - WB: A <= result_r; carry, zero, neg and ovf flags updated; done=1 for the following cycle; next state IDLE.
- Latency: start sampled at edge k. A and flags are valid after edge k+2, and done is high in the cycle after edge k+2. A new start is accepted at edge k+3 at the earliest, when done is high and state is IDLE.
- Simultaneous la/lb and start in IDLE: the loads take effect at edge k. The operation uses the newly loaded values, because operands are read in EXEC.
- la, lb and start are ignored while busy=1. Operands are guaranteed stable during EXEC.
- Arithmetic:
  - Add: {carry, result} = A + B, modulo 2^WIDTH.
  - Subtract: A + ~B + 1. carry = carry-out, so A>=B unsigned gives carry=1.
  - Overflow: ovf = (A[MSB] == Bop[MSB]) && (result[MSB] != A[MSB]), where Bop = B for add and ~B for subtract.
- Flags are held between operations; la and lb do not change them.
- ea is purely combinational (no register stage) and is legal in any state. It shows the current A, including mid-operation, when A still holds the pre-operation value until WB.

Decomposition:
- Shared package: WIDTH default constant; FSM state encoding (IDLE=2'd0, EXEC=2'd1, WB=2'd2); op encoding (OP_ADD=0, OP_SUB=1).
- One sub-module: the existing adder_subtracter (8-bit, a/b/SUB/s/carry), instantiated once with a=A, b=B, SUB=op_r.
- Overflow is computed locally from the operand and result MSBs.

Test Plan:
1. Assert rst for 2 cycles with ea=1 -> a_q=b_q=0x00, bus_out=0x00, all flags 0, busy=0, done=0.
2. Load A=0x05 and B=0x03, start su=0 at edge k -> busy high over k..k+2, done pulse after k+2, A=0x08, C=0, Z=0, N=0, V=0.
3. A=0xFF, B=0x01, add -> A=0x00, C=1, Z=1, N=0, V=0.
4. A=0x03, B=0x05, subtract -> A=0xFE, C=0 (borrow), Z=0, N=1, V=0. Repeat with A=0x05, B=0x03 -> A=0x02, C=1.
5. A=0x7F, B=0x01, add -> A=0x80, N=1, V=1. Then A=0x80, B=0x01, subtract -> A=0x7F, V=1. Pulse la with bus_in=0xAA during busy -> ignored, result unaffected.
6. Start an add, assert rst at edge k+1 -> no done pulse, A=0x00, state IDLE. Simultaneous la (bus_in=0x10) with start and B=0x01 -> A=0x11.
